// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package serial_adder_pkg;

   // FSM encoding: the numeric values are visible on debug taps, so keep them fixed.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Digit counter width: clog2(steps), but never narrower than one bit.
   function automatic int cnt_width(input int steps);
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple-carry slice used once per clock by serial_adder.
// Latency: purely combinational.
// Backpressure: none; the caller sequences digits.
module adder_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb
);

   logic [DIGIT:0] c;

   // Ripple the carry from bit 0 upward through the slice.
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
      end
   end

   assign co    = c[DIGIT];
   // Carry into the top bit of the slice; on the last digit this is the carry into the word MSB.
   assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder, DIGIT bits per clock; SERIAL_ADDER_SUB_EN adds subtract mode and ovf.
// Latency: done pulses STEPS cycles after the accepting edge; back-to-back every STEPS+1 cycles.
// Backpressure: start is only taken in IDLE or DONE; start during RUN is dropped.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_SUB_EN
   ,
   input  logic             sub,
   output logic             ovf
`endif
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = cnt_width(STEPS);
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic             carry;
   logic             carry_init;
   logic [CW-1:0]    cnt;
   logic             sub_q;
   logic             accept;
   logic             last_step;
   logic [DIGIT-1:0] dig_b;
   logic [DIGIT-1:0] dig_s;
   logic             dig_co;
   logic             dig_cmsb;

   assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign last_step = (state == ST_RUN) && (cnt == LAST);
   // Subtraction feeds the inverted B digit; the +1 comes from the initial carry.
   assign dig_b     = sub_q ? ~b_sh[DIGIT-1:0] : b_sh[DIGIT-1:0];

   adder_digit #(.DIGIT(DIGIT)) u_digit (
      .a     (a_sh[DIGIT-1:0]),
      .b     (dig_b),
      .ci    (carry),
      .s     (dig_s),
      .co    (dig_co),
      .c_msb (dig_cmsb)
   );

   // Result digits enter at the MSB end so the word is aligned after the last step.
   generate
      if (WIDTH == DIGIT) begin : g_acc_single
         assign acc_next = dig_s;
      end else begin : g_acc_shift
         assign acc_next = {dig_s, acc[WIDTH-1:DIGIT]};
      end
   endgenerate

`ifdef SERIAL_ADDER_SUB_EN
   assign carry_init = sub ? 1'b1 : cin;

   // Operation mode is latched with the operands; ovf is updated only with the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sub_q <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         if (accept)
            sub_q <= sub;
         if (last_step)
            ovf <= dig_cmsb ^ dig_co;
      end
   end
`else
   logic unused_c_msb;
   assign carry_init   = cin;
   assign sub_q        = 1'b0;
   assign unused_c_msb = dig_cmsb;
`endif

   // Control FSM plus datapath registers; sum/cout move only on the final RUN edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         cnt   <= '0;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         carry <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= carry_init;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               acc   <= acc_next;
               carry <= dig_co;
               cnt   <= cnt + 1'b1;
               if (last_step) begin
                  sum   <= acc_next;
                  cout  <= dig_co;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three parameterisations share one clock and reset.
// Latency: expected results queued at start, checked when done pulses.
// Backpressure: start during RUN and back-to-back restarts from DONE are exercised.
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   // WIDTH=4, DIGIT=1
   logic       st4, ci4, busy4, done4, cout4;
   logic [3:0] a4, b4, sum4;
   // WIDTH=8, DIGIT=1
   logic       st8, ci8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   // WIDTH=8, DIGIT=4
   logic       st84, ci84, busy84, done84, cout84;
   logic [7:0] a84, b84, sum84;
`ifdef SERIAL_ADDER_SUB_EN
   logic       sub4, ovf4, sub8, ovf8, sub84, ovf84;
`endif

   serial_adder #(.WIDTH(4), .DIGIT(1)) u4 (
      .clk(clk), .rst(rst), .start(st4), .a(a4), .b(b4), .cin(ci4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_SUB_EN
      , .sub(sub4), .ovf(ovf4)
`endif
   );

   serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
      .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .cin(ci8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_SUB_EN
      , .sub(sub8), .ovf(ovf8)
`endif
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u84 (
      .clk(clk), .rst(rst), .start(st84), .a(a84), .b(b84), .cin(ci84),
      .busy(busy84), .done(done84), .sum(sum84), .cout(cout84)
`ifdef SERIAL_ADDER_SUB_EN
      , .sub(sub84), .ovf(ovf84)
`endif
   );

   task automatic test_reset();
      rst = 1'b1;
      st4 = 0; a4 = 0; b4 = 0; ci4 = 0;
      st8 = 0; a8 = 0; b8 = 0; ci8 = 0;
      st84 = 0; a84 = 0; b84 = 0; ci84 = 0;
`ifdef SERIAL_ADDER_SUB_EN
      sub4 = 0; sub8 = 0; sub84 = 0;
`endif
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy4, done4, cout4, sum4} !== 7'd0) begin
         n_fail++; $display("FAIL reset_w4: got %h expected 0", {busy4, done4, cout4, sum4});
      end
      n_checks++;
      if ({busy8, done8, cout8, sum8} !== 11'd0) begin
         n_fail++; $display("FAIL reset_w8: got %h expected 0", {busy8, done8, cout8, sum8});
      end
      n_checks++;
      if ({busy84, done84, cout84, sum84} !== 11'd0) begin
         n_fail++; $display("FAIL reset_w8d4: got %h expected 0", {busy84, done84, cout84, sum84});
      end
`ifdef SERIAL_ADDER_SUB_EN
      n_checks++;
      if ({ovf4, ovf8, ovf84} !== 3'd0) begin
         n_fail++; $display("FAIL reset_ovf: got %b expected 000", {ovf4, ovf8, ovf84});
      end
`endif
      rst = 1'b0;
      @(negedge clk);
   endtask

   // All 512 operand combinations, each restarted straight from DONE.
   task automatic test_exhaustive_w4();
      logic [8:0] v, got;
      int cyc;
      for (int i = 0; i < 512; i++) begin
         v   = 9'(i);
         a4  = v[3:0];
         b4  = v[7:4];
         ci4 = v[8];
         exp_q.push_back(9'(a4) + 9'(b4) + 9'(ci4));
         st4 = 1'b1;
         @(negedge clk);
         st4 = 1'b0;
         cyc = 0;
         while (!done4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
         end
         n_checks++;
         if (cyc != 4) begin
            n_fail++;
            if (n_fail < 20) $display("FAIL w4_latency a=%h b=%h: got %0d expected 4", a4, b4, cyc);
         end
         got = exp_q.pop_front();
         n_checks++;
         if ({cout4, sum4} !== got[4:0]) begin
            n_fail++;
            if (n_fail < 20) $display("FAIL w4_sum a=%h b=%h cin=%b: got %h expected %h", a4, b4, ci4, {cout4, sum4}, got[4:0]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_w8_carry();
      int busy_cnt = 0, done_cnt = 0, done_at = -1;
      logic [8:0] got;
      a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0;
      exp_q.push_back(9'(a8) + 9'(b8) + 9'(ci8));
      st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (busy8) busy_cnt++;
         if (done8) begin
            done_cnt++;
            done_at = k;
            got = exp_q.pop_front();
            n_checks++;
            if ({cout8, sum8} !== got) begin
               n_fail++; $display("FAIL w8_carry_sum: got %h expected %h", {cout8, sum8}, got);
            end
`ifdef SERIAL_ADDER_SUB_EN
            n_checks++;
            if (ovf8 !== 1'b0) begin
               n_fail++; $display("FAIL w8_carry_ovf: got %b expected 0", ovf8);
            end
`endif
         end
         @(negedge clk);
      end
      n_checks++;
      if (busy_cnt != 8) begin
         n_fail++; $display("FAIL w8_busy_cycles: got %0d expected 8", busy_cnt);
      end
      n_checks++;
      if (done_cnt != 1) begin
         n_fail++; $display("FAIL w8_done_pulses: got %0d expected 1", done_cnt);
      end
      n_checks++;
      if (done_at != 8) begin
         n_fail++; $display("FAIL w8_latency: got %0d expected 8", done_at);
      end
      while (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   task automatic test_w8_digit4();
      int cyc = 0;
      logic [8:0] got;
      a84 = 8'h3C; b84 = 8'h4B; ci84 = 1'b1;
      exp_q.push_back(9'(a84) + 9'(b84) + 9'(ci84));
      st84 = 1'b1;
      @(negedge clk);
      st84 = 1'b0;
      while (!done84 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (cyc != 2) begin
         n_fail++; $display("FAIL w8d4_latency: got %0d expected 2", cyc);
      end
      got = exp_q.pop_front();
      n_checks++;
      if ({cout84, sum84} !== got) begin
         n_fail++; $display("FAIL w8d4_sum: got %h expected %h", {cout84, sum84}, got);
      end
      repeat (2) @(negedge clk);
   endtask

   // Start pulsed mid-RUN with new operands must not disturb the first result.
   task automatic test_back_to_back();
      int cyc = 0;
      logic [8:0] got;
      a8 = 8'h12; b8 = 8'h34; ci8 = 1'b1;
      exp_q.push_back(9'(a8) + 9'(b8) + 9'(ci8));
      st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      repeat (2) @(negedge clk);
      a8 = 8'hAA; b8 = 8'hAA; ci8 = 1'b0;
      st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      cyc = 3;
      while (!done8 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (cyc != 8) begin
         n_fail++; $display("FAIL ignored_start_latency: got %0d expected 8", cyc);
      end
      got = exp_q.pop_front();
      n_checks++;
      if ({cout8, sum8} !== got) begin
         n_fail++; $display("FAIL ignored_start_sum: got %h expected %h", {cout8, sum8}, got);
      end
      // Restart from DONE in the same cycle done is seen.
      a8 = 8'hC8; b8 = 8'h64; ci8 = 1'b0;
      exp_q.push_back(9'(a8) + 9'(b8) + 9'(ci8));
      st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      cyc = 1;
      while (!done8 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (cyc != 9) begin
         n_fail++; $display("FAIL back_to_back_period: got %0d expected 9", cyc);
      end
      got = exp_q.pop_front();
      n_checks++;
      if ({cout8, sum8} !== got) begin
         n_fail++; $display("FAIL back_to_back_sum: got %h expected %h", {cout8, sum8}, got);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_midrun();
      int cyc = 0, done_cnt = 0;
      logic [8:0] got;
      a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0;
      st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy8, done8, cout8, sum8} !== 11'd0) begin
         n_fail++; $display("FAIL midrun_reset_outputs: got %h expected 0", {busy8, done8, cout8, sum8});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (done8) done_cnt++;
         @(negedge clk);
      end
      n_checks++;
      if (done_cnt != 0) begin
         n_fail++; $display("FAIL midrun_no_done: got %0d expected 0", done_cnt);
      end
      exp_q.push_back(9'(a8) + 9'(b8) + 9'(ci8));
      st8 = 1'b1;
      @(negedge clk);
      st8 = 1'b0;
      while (!done8 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      got = exp_q.pop_front();
      n_checks++;
      if ({cout8, sum8} !== got || cyc != 8) begin
         n_fail++; $display("FAIL midrun_restart: got %h after %0d expected %h after 8", {cout8, sum8}, cyc, got);
      end
      repeat (2) @(negedge clk);
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_subtract();
      logic [7:0] av[2], bv[2], bn;
      logic [8:0] r, got;
      logic exp_ovf;
      int cyc;
      av[0] = 8'h05; bv[0] = 8'h07;
      av[1] = 8'h80; bv[1] = 8'h01;
      for (int i = 0; i < 2; i++) begin
         a8 = av[i]; b8 = bv[i]; ci8 = 1'b0; sub8 = 1'b1;
         bn = ~b8;
         r  = 9'(a8) + 9'(bn) + 9'd1;
         exp_ovf = (a8[7] == bn[7]) && (r[7] != a8[7]);
         exp_q.push_back(r);
         st8 = 1'b1;
         @(negedge clk);
         st8 = 1'b0; sub8 = 1'b0;
         cyc = 0;
         while (!done8 && cyc < 30) begin
            @(negedge clk);
            cyc++;
         end
         got = exp_q.pop_front();
         n_checks++;
         if ({cout8, sum8} !== got) begin
            n_fail++; $display("FAIL sub_%0d_result: got %h expected %h", i, {cout8, sum8}, got);
         end
         n_checks++;
         if (ovf8 !== exp_ovf) begin
            n_fail++; $display("FAIL sub_%0d_ovf: got %b expected %b", i, ovf8, exp_ovf);
         end
         repeat (2) @(negedge clk);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_exhaustive_w4();
      test_w8_carry();
      test_w8_digit4();
      test_back_to_back();
      test_reset_midrun();
`ifdef SERIAL_ADDER_SUB_EN
      test_subtract();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
